// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions used by fetch, decode and signext.
// Holds the datapath widths and the {instr, pc} entry passed from fetch to decode.
package legv8_pkg;

   localparam int N       = 64;
   localparam int INSTR_W = 32;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [N-1:0]       pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry skid FIFO between the instruction memory and decode.
// A flush empties it in one edge. The storage is not cleared by a flush, only by reset.
module fetch_fifo2
   import legv8_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  fetch_entry_t i_data,
   output fetch_entry_t o_head,
   output logic [1:0]   o_count,
   output logic         o_full,
   output logic         o_empty
);

   fetch_entry_t r_mem [2];
   logic         r_wrPtr;
   logic         r_rdPtr;
   logic [1:0]   r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wrPtr  <= 1'b0;
         r_rdPtr  <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_wrPtr  <= 1'b0;
         r_rdPtr  <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wrPtr] <= i_data;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (i_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         // A simultaneous push and pop leaves the occupancy unchanged.
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rdPtr];
   assign o_count = r_count;
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch: owns the PC, issues reads to the synchronous imem,
// and hands {instr, pc} to decode through a 2-entry skid buffer with branch redirect.
module fetch_unit #(
   parameter int N      = 64,
   parameter int ADDR_W = 6
)(
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_q,
   output logic [31:0]       instr,
   output logic [N-1:0]      instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [N-1:0]      redirect_pc,
   input  logic [N-1:0]      redirect_imm
);

   import legv8_pkg::*;

   logic [N-1:0] r_pc;
   logic [N-1:0] r_inflightPc;
   logic         r_inflight;

   fetch_entry_t w_pushData;
   fetch_entry_t w_head;
   logic [1:0]   w_count;
   logic         w_full;
   logic         w_empty;
   logic         w_pop;
   logic         w_issue;
   logic [2:0]   w_occupancy;
   logic [N-1:0] w_target;

   // A redirect cycle never counts as a pop, even with decode ready.
   assign w_pop       = instr_valid && instr_ready && !redirect;
   assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue     = !redirect && (w_occupancy < 3'd2);
   assign w_target    = (redirect_pc & ~N'(3)) + (redirect_imm << 2);
   assign w_pushData  = '{instr: imem_q, pc: r_inflightPc};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc         <= '0;
         r_inflight   <= 1'b0;
         r_inflightPc <= '0;
      end else if (redirect) begin
         r_pc       <= w_target;
         r_inflight <= 1'b0;
      end else if (w_issue) begin
         r_inflight   <= 1'b1;
         r_inflightPc <= r_pc;
         r_pc         <= r_pc + N'(4);
      end else begin
         r_inflight <= 1'b0;
      end
   end

   fetch_fifo2 u_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (r_inflight),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .i_data  (w_pushData),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign imem_addr   = r_pc[ADDR_W+1:2];
   assign instr_valid = !w_empty;
   assign instr       = w_head.instr;
   assign instr_pc    = w_head.pc;

   // Issue throttling guarantees a returning word always finds a free slot.
   assert property (@(posedge clk) disable iff (reset) !(r_inflight && !redirect && w_full));

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the LEGv8 single-cycle/pipelined core: it owns the PC, issues word reads to the synchronous instruction memory, and delivers instruction words with their PC to decode (where `signext` and the decoder consume them) over a valid/ready handshake. It also accepts branch redirects whose offset is the already sign-extended immediate produced by `signext`. A 2-entry skid buffer keeps full throughput when decode stalls.

## Interface
Parameters:
- `N` = 64: PC and immediate width.
- `ADDR_W` = 6: instruction-memory word-address width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_addr`  out  ADDR_W  word address, equal to `pc[ADDR_W+1:2]`, combinational from `pc`.
- `imem_q`  in  32  read data, valid in the cycle after the address was sampled.
- `instr`  out  32  instruction word at the buffer head.
- `instr_pc`  out  N  byte PC of `instr`.
- `instr_valid`  out  1  buffer head holds a valid instruction.
- `instr_ready`  in  1  decode accepts the head this cycle.
- `redirect`  in  1  taken branch; flush and refetch.
- `redirect_pc`  in  N  byte PC of the branch.
- `redirect_imm`  in  N  sign-extended word offset (`signext` output).

## Operation
- State: `pc` (next byte address to read), `inflight` (1 bit, read issued last edge), `inflight_pc`, and a 2-entry FIFO of {instr, pc} with `count` 0..2.
- `pop` = `instr_valid && instr_ready`. `push` = `inflight` (the data on `imem_q` is captured into the FIFO).
- Issue rule: `issue` = `!redirect && (count + inflight - pop) < 2`. On issue: `inflight`<=1, `inflight_pc`<=`pc`, `pc`<=`pc`+4. Otherwise `inflight`<=0.
- Push and pop may occur in the same cycle; `count` is unchanged and ordering is preserved. The FIFO never overflows by construction. A push to a full FIFO is a design error and must be flagged by an assertion.
- Redirect has priority over all other activity:
  - target = `{redirect_pc[N-1:2],2'b00}` + (`redirect_imm` << 2), modulo 2^N.
  - `pc`<=target; FIFO flushed (`count`<=0); `inflight`<=0, so the `imem_q` word returning next cycle is discarded.
  - No pop is considered taken in a redirect cycle, even if `instr_ready`=1.
- PC bits above `ADDR_W+1` do not affect `imem_addr`. The memory aliases and the PC wraps at 2^N.
- Reset values: `pc`=0, `inflight`=0, `count`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `imem_addr`=0. Reset asserted mid-operation discards all buffered and in-flight words and overrides `redirect`.

## Timing
- Reset release to first `instr_valid`: the first rising edge with `reset`=0 issues a read of PC 0. The next edge pushes that word. `instr_valid`=1 from then on, i.e. two edges of latency.
- Steady state with `instr_ready`=1: one instruction per cycle, PCs 0, 4, 8, …
- Stall (`instr_ready`=0): at most 2 words are held. Issuing stops once `count`+`inflight`=2. After `instr_ready` returns, delivery resumes the same cycle from the buffer with no bubble.
- Redirect at edge k: `instr_valid`=0 after edge k. Target read issues at edge k+1. The target instruction is valid after edge k+2.
- `instr`/`instr_pc` are stable while `instr_valid`=1 and `instr_ready`=0.

## Structure
- Shared package `legv8_pkg`: `N`, `INSTR_W`=32, and the `fetch_entry_t` struct {instr, pc}. The decoder and `signext` use the same package.
- One sub-module: `fetch_fifo2`, a 2-entry synchronous FIFO of `fetch_entry_t` with push/pop/flush, `count`, and `full`/`empty`. The PC, issue and redirect logic stay in `fetch_unit`.

## Test plan
- Reset held 3 cycles, then released with `instr_ready`=1 and imem preloaded `mem[i]`=i -> `instr_valid` rises after edge 2; `instr_pc`=0,4,8,… with `instr`=0,1,2,… on consecutive cycles.
- `instr_ready`=0 for 5 cycles from PC 0x8 onward -> exactly 2 words are held (0x8, 0xC); `imem_addr` stops advancing at 4. On release, 0x8 and 0xC are delivered back-to-back with no bubble.
- Redirect with `redirect_pc`=0x10, `redirect_imm`=0xf -> target 0x4C; next valid `instr_pc`=0x4C and `imem_addr`=0x13. The discarded in-flight word never appears.
- Negative offset with `redirect_pc`=0x1000, `redirect_imm`=64'hfffffffffffd8ba1 -> target 64'hFFFFFFFFFFF63E84 and `imem_addr`=0x21.
- Redirect while the FIFO is full and `instr_ready`=1 in the same cycle -> no pop is counted; `count`=0 and `instr_valid`=0 next cycle.
- `reset` asserted with 2 buffered words and a redirect pending -> all outputs return to 0. The sequence restarts at PC 0, not at the redirect target.
